// File: rtl/bpsk_nco.sv
// BPSK carrier NCO: phase accumulator with symbol-driven 180-degree inversion and a quarter-wave sine table.
// Latency: 3 advance cycles from phase injection to out_valid with the matching sample.
// Backpressure: the whole pipeline and the accumulator freeze while out_valid is high and out_ready is low.
module bpsk_nco #(
    parameter int DATA_WIDTH     = 12,
    parameter int PHASE_WIDTH    = 24,
    parameter int LUT_ADDR_WIDTH = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [PHASE_WIDTH-1:0]       freq_word,
    input  logic [PHASE_WIDTH-1:0]       phase_offset,
    input  logic                         bpsk_bit,
    input  logic                         bit_strobe,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] sample
);

    localparam int LUT_DEPTH = 1 << LUT_ADDR_WIDTH;
    localparam logic [PHASE_WIDTH-1:0] HALF_TURN = {1'b1, {(PHASE_WIDTH-1){1'b0}}};

    // Quarter-wave sample taken at the centre of each bin, so no entry is zero
    // and the amplitude never reaches the most-negative code.
    function automatic logic signed [DATA_WIDTH-1:0] lut_entry(input int idx);
        real amp;
        real ang;
        amp = real'((1 << (DATA_WIDTH-1)) - 1);
        ang = 3.14159265358979323846 / 2.0 * (real'(idx) + 0.5) / real'(LUT_DEPTH);
        return DATA_WIDTH'($rtoi(amp * $sin(ang) + 0.5));
    endfunction

    logic signed [DATA_WIDTH-1:0] lut [LUT_DEPTH];

    for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_lut
        localparam logic signed [DATA_WIDTH-1:0] ENTRY = lut_entry(g);
        assign lut[g] = ENTRY;
    end

    // State
    logic [PHASE_WIDTH-1:0]       acc_q, acc_d;
    logic                         pending_q, pending_d;
    logic                         sym_q;
    logic [PHASE_WIDTH-1:0]       p_q, p_d;
    logic                         v0_q;
    logic [1:0]                   q_q, q_d;
    logic [LUT_ADDR_WIDTH-1:0]    a_q, a_d;
    logic                         v1_q;
    logic signed [DATA_WIDTH-1:0] sample_q, sample_d;
    logic                         out_valid_q;

    logic                         advance;
    logic                         inject;
    logic [PHASE_WIDTH:0]         acc_sum;
    logic                         wrap;
    logic [LUT_ADDR_WIDTH-1:0]    a_raw;
    logic signed [DATA_WIDTH-1:0] lut_val;

    assign advance = !(out_valid_q && !out_ready);
    assign inject  = advance && enable;

    // Stage-0 phase point, accumulator step and carrier-wrap detection
    always_comb begin
        acc_sum   = {1'b0, acc_q} + {1'b0, freq_word};
        wrap      = acc_sum[PHASE_WIDTH];
        acc_d     = acc_sum[PHASE_WIDTH-1:0];
        // A strobe coinciding with a wrap must be the value applied at that wrap
        pending_d = bit_strobe ? bpsk_bit : pending_q;
        p_d       = acc_q + phase_offset + (sym_q ? HALF_TURN : '0);
    end

    // Stage-1 quadrant split with address mirroring on odd quadrants
    always_comb begin
        q_d   = p_q[PHASE_WIDTH-1:PHASE_WIDTH-2];
        a_raw = p_q[PHASE_WIDTH-3 -: LUT_ADDR_WIDTH];
        a_d   = q_d[0] ? ~a_raw : a_raw;
    end

    // Stage-2 table lookup, negated in the lower half-plane
    always_comb begin
        lut_val  = lut[a_q];
        sample_d = q_q[1] ? -lut_val : lut_val;
    end

    // Symbol capture: pending follows every strobe, sym only switches on a wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            sym_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (inject && wrap) begin
                sym_q <= pending_d;
            end
        end
    end

    // Accumulator and stage-0 register, injecting a point or a bubble each advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            p_q   <= '0;
            v0_q  <= 1'b0;
        end else if (advance) begin
            v0_q <= enable;
            if (enable) begin
                acc_q <= acc_d;
                p_q   <= p_d;
            end
        end
    end

    // Stage-1 and stage-2 registers, all frozen together on a stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q         <= '0;
            a_q         <= '0;
            v1_q        <= 1'b0;
            sample_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (advance) begin
            q_q         <= q_d;
            a_q         <= a_d;
            v1_q        <= v0_q;
            sample_q    <= sample_d;
            out_valid_q <= v1_q;
        end
    end

    assign out_valid = out_valid_q;
    assign sample    = sample_q;

    // Fine phase bits below the table address and the quadrant LSB after mirroring are intentionally dropped
    logic unused_bits;
    assign unused_bits = ^{p_q[PHASE_WIDTH-LUT_ADDR_WIDTH-3:0], q_q[0]};

endmodule

// File: tb/tb_bpsk_nco.sv
module tb_bpsk_nco;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic [23:0]        freq_word;
    logic [23:0]        phase_offset;
    logic               bpsk_bit;
    logic               bit_strobe;
    logic               out_ready;
    logic               out_valid;
    logic signed [11:0] sample;

    int checks = 0;
    int errors = 0;

    bpsk_nco dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .freq_word    (freq_word),
        .phase_offset (phase_offset),
        .bpsk_bit     (bpsk_bit),
        .bit_strobe   (bit_strobe),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .sample       (sample)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    int exp_a [12] = '{25, 2047, -25, -2047, -25, -2047, 25, 2047, 25, 2047, -25, -2047};
    int exp_b [6]  = '{25, 2047, -25, -2047, 25, 2047};
    int exp_cv [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
    int exp_cs [8] = '{25, 0, 2047, 0, -25, 0, -2047, 0};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        enable       = 1'b1;
        freq_word    = 24'h400000;
        phase_offset = 24'h000000;
        bpsk_bit     = 1'b0;
        bit_strobe   = 1'b0;
        out_ready    = 1'b1;
        step();
        check("reset_valid", int'(out_valid), 0);
        check("reset_sample", int'(sample), 0);

        // A: basic stream, strobe with no wrap, then strobe coinciding with a wrap
        do_reset();
        for (int s = 1; s <= 14; s++) begin
            bit_strobe = (s == 1) || (s == 8);
            bpsk_bit   = (s == 1);
            step();
            bit_strobe = 1'b0;
            bpsk_bit   = 1'b0;
            if (s < 3) begin
                check($sformatf("A_latency_valid[%0d]", s), int'(out_valid), 0);
            end else begin
                check($sformatf("A_valid[%0d]", s - 3), int'(out_valid), 1);
                check($sformatf("A_sample[%0d]", s - 3), int'(sample), exp_a[s-3]);
            end
        end

        // B: five-cycle stall mid-stream
        do_reset();
        for (int s = 1; s <= 5; s++) begin
            step();
            if (s >= 3) check($sformatf("B_sample[%0d]", s - 3), int'(sample), exp_b[s-3]);
        end
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("B_stall_valid[%0d]", k), int'(out_valid), 1);
            check($sformatf("B_stall_sample[%0d]", k), int'(sample), -25);
        end
        out_ready = 1'b1;
        for (int j = 3; j < 6; j++) begin
            step();
            check($sformatf("B_resume_valid[%0d]", j), int'(out_valid), 1);
            check($sformatf("B_resume_sample[%0d]", j), int'(sample), exp_b[j]);
        end

        // C: enable toggling produces bubbles and holds the accumulator
        do_reset();
        for (int s = 1; s <= 10; s++) begin
            enable = (s <= 8) && (s % 2 == 1);
            step();
            if (s >= 3) begin
                check($sformatf("C_valid[%0d]", s), int'(out_valid), exp_cv[s-3]);
                if (exp_cv[s-3] == 1) check($sformatf("C_sample[%0d]", s), int'(sample), exp_cs[s-3]);
            end
        end
        enable = 1'b1;

        // D: asynchronous reset with samples in flight
        do_reset();
        for (int s = 1; s <= 4; s++) begin
            step();
            if (s >= 3) check($sformatf("D_pre_sample[%0d]", s), int'(sample), exp_b[s-3]);
        end
        rst_n = 1'b0;
        #1;
        check("D_async_valid", int'(out_valid), 0);
        check("D_async_sample", int'(sample), 0);
        step();
        check("D_hold_valid", int'(out_valid), 0);
        rst_n = 1'b1;
        for (int s = 1; s <= 3; s++) begin
            step();
            if (s == 2) check("D_restart_latency", int'(out_valid), 0);
            if (s == 3) begin
                check("D_restart_valid", int'(out_valid), 1);
                check("D_restart_sample", int'(sample), 25);
            end
        end

        // E: zero frequency gives a constant sample; strobe has no effect without a wrap
        freq_word    = 24'h000000;
        phase_offset = 24'h800000;
        do_reset();
        for (int s = 1; s <= 8; s++) begin
            bit_strobe = (s == 2);
            bpsk_bit   = (s == 2);
            step();
            bit_strobe = 1'b0;
            bpsk_bit   = 1'b0;
            if (s >= 3) check($sformatf("E_sample[%0d]", s), int'(sample), -25);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
